// File: rtl/mvau_inp_buffer.sv
// mvau_inp_buffer
//
// Input-activation buffer in front of the matrix-vector unit. One input
// vector arrives as SF words of SIMD activations. Each word is forwarded to
// the MVU as soon as it is accepted and is also stored. Once the vector is
// complete, the stored copy is replayed NF-1 more times so that every PE fold
// sees the full vector.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active HIGH despite its name
//   in_v         input word valid
//   in_rdy       buffer can take an input word this cycle
//   in_data      input word, activation k at [k*TSrcI +: TSrcI]
//   out_v        output word valid
//   out_rdy      MVU takes the output word this cycle
//   out_data     activation word to the MVU
//   out_sf_last  out_data is the last word of the current pass
//   out_last     out_data is the last word of the last pass of this vector
module mvau_inp_buffer #(
  parameter int unsigned SIMD    = 2,
  parameter int unsigned TSrcI   = 4,
  parameter int unsigned MatrixW = 8,
  parameter int unsigned MatrixH = 6,
  parameter int unsigned PE      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_v,
  output logic                  in_rdy,
  input  logic [SIMD*TSrcI-1:0] in_data,
  output logic                  out_v,
  input  logic                  out_rdy,
  output logic [SIMD*TSrcI-1:0] out_data,
  output logic                  out_sf_last,
  output logic                  out_last
);

  localparam int unsigned W  = SIMD * TSrcI;
  localparam int unsigned SF = MatrixW / SIMD;
  localparam int unsigned NF = MatrixH / PE;
  localparam int unsigned PW = (SF > 1) ? $clog2(SF) : 1;
  localparam int unsigned NW = (NF > 1) ? $clog2(NF) : 1;

  localparam logic [PW-1:0] SF_MAX = PW'(SF - 1);
  localparam logic [NW-1:0] NF_MAX = NW'(NF - 1);

  // Refuse to elaborate with a fold configuration that cannot be built.
  if ((SF < 1) || (NF < 1) || ((MatrixW % SIMD) != 0) || ((MatrixH % PE) != 0))
  begin : g_bad_params
    $error("mvau_inp_buffer: MatrixW/SIMD and MatrixH/PE must be whole numbers >= 1");
  end

  typedef enum logic {
    FILL,
    REPLAY
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   nf_cnt_q, nf_cnt_d;
  logic            out_v_q, out_v_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_sf_last_q, out_sf_last_d;
  logic            out_last_q, out_last_d;

  logic [W-1:0]    mem_q [SF];
  logic [W-1:0]    rd_word;
  logic            load;
  logic            accept;
  logic            wr_last;
  logic            rd_last;
  logic            nf_last;

  // Storage is not reset: every entry is written in FILL before REPLAY reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Asynchronous read lets the first replay word follow the last fill word
  // without a bubble, even when the vector is a single word.
  assign rd_word = mem_q[rd_ptr_q];

  assign wr_last = (wr_ptr_q == SF_MAX);
  assign rd_last = (rd_ptr_q == SF_MAX);
  assign nf_last = (nf_cnt_q == NF_MAX);

  // The output register advances whenever it is empty or being drained.
  // in_rdy is also gated by reset so nothing is offered while reset is held.
  always_comb begin
    load   = !out_v_q || out_rdy;
    in_rdy = (state_q == FILL) && load && !rst_n;
    accept = in_v && in_rdy;
  end

  // Next-state logic: FILL forwards and stores, REPLAY re-reads storage.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    nf_cnt_d      = nf_cnt_q;
    out_v_d       = out_v_q;
    out_data_d    = out_data_q;
    out_sf_last_d = out_sf_last_q;
    out_last_d    = out_last_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          out_v_d       = 1'b1;
          out_data_d    = in_data;
          out_sf_last_d = wr_last;
          out_last_d    = wr_last && (NF == 1);
          if (wr_last) begin
            wr_ptr_d = '0;
            if (NF > 1) begin
              state_d  = REPLAY;
              rd_ptr_d = '0;
              nf_cnt_d = NW'(1);
            end
          end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
          end
        end else if (load) begin
          // Input starved: the drained word is not repeated.
          out_v_d = 1'b0;
        end
      end

      REPLAY: begin
        if (load) begin
          out_v_d       = 1'b1;
          out_data_d    = rd_word;
          out_sf_last_d = rd_last;
          out_last_d    = rd_last && nf_last;
          if (rd_last) begin
            rd_ptr_d = '0;
            if (nf_last) begin
              state_d  = FILL;
              nf_cnt_d = '0;
              wr_ptr_d = '0;
            end else begin
              nf_cnt_d = nf_cnt_q + NW'(1);
            end
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // State and output register; reset discards any partial vector.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      nf_cnt_q      <= '0;
      out_v_q       <= 1'b0;
      out_data_q    <= '0;
      out_sf_last_q <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      nf_cnt_q      <= nf_cnt_d;
      out_v_q       <= out_v_d;
      out_data_q    <= out_data_d;
      out_sf_last_q <= out_sf_last_d;
      out_last_q    <= out_last_d;
    end
  end

  assign out_v       = out_v_q;
  assign out_data    = out_data_q;
  assign out_sf_last = out_sf_last_q;
  assign out_last    = out_last_q;

endmodule

// File: tb/tb_mvau_inp_buffer.sv
// tb_mvau_inp_buffer
//
// Drives three buffer instances from one shared input stream:
//   dut 0: default folding (SF=4, NF=3)
//   dut 1: single PE fold   (SF=4, NF=1)
//   dut 2: single-word vector (SF=1, NF=3)
// Each instance is followed by a position-based model: a vector occupies
// SF*NF consecutive output loads, the first SF of which are the accepted input
// words and the rest repeat them in order.
`timescale 1ns/1ps
module tb_mvau_inp_buffer;

  localparam int NDUT = 3;
  localparam int W    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          inV;
  logic          outRdy;
  logic [W-1:0]  inData;

  logic          inRdy   [NDUT];
  logic          outV    [NDUT];
  logic [W-1:0]  outData [NDUT];
  logic          outSfl  [NDUT];
  logic          outLast [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdyMode = 0;

  // Hand-derived fold counts for the three configurations.
  int sfOf [NDUT] = '{4, 4, 1};
  int nfOf [NDUT] = '{3, 1, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int MW = (g == 2) ? 2 : 8;
    localparam int MH = (g == 1) ? 2 : 6;
    mvau_inp_buffer #(
      .SIMD(2), .TSrcI(4), .MatrixW(MW), .MatrixH(MH), .PE(2)
    ) u_dut (
      .clk(clk),
      .rst_n(rst),
      .in_v(inV),
      .in_rdy(inRdy[g]),
      .in_data(inData),
      .out_v(outV[g]),
      .out_rdy(outRdy),
      .out_data(outData[g]),
      .out_sf_last(outSfl[g]),
      .out_last(outLast[g])
    );
  end

  // Handshaked output words of dut 0 and dut 1, used by the directed tests.
  typedef struct {
    logic [W-1:0] data;
    logic         sfl;
    logic         last;
    int           cyc;
  } ent_t;
  ent_t log0[$];
  ent_t log1[$];

  // Model state: next load position within the vector, and the vector itself.
  int           pos       [NDUT];
  logic [W-1:0] vec       [NDUT][4];
  bit           prevValid [NDUT];
  bit           pLoad     [NDUT];
  bit           pInAcc    [NDUT];
  logic [W-1:0] pData     [NDUT];
  logic         pSfl      [NDUT];
  logic         pLast     [NDUT];
  logic [W-1:0] pInData;

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual=%0h required=%0h at cycle %0d",
               name, d, act, exp, cyc);
    end
  endtask

  // Compare the word just loaded into the output register with the model.
  task automatic expectWord(input int d);
    int sf, nf, idx;
    sf  = sfOf[d];
    nf  = nfOf[d];
    idx = pos[d] % sf;
    checkOutput("out_data", d, 32'(outData[d]), 32'(vec[d][idx]));
    checkOutput("out_sf_last", d, 32'(outSfl[d]), 32'(idx == sf - 1));
    checkOutput("out_last", d, 32'(outLast[d]), 32'(pos[d] == sf * nf - 1));
    pos[d] = (pos[d] + 1) % (sf * nf);
  endtask

  // Single compare process: at every falling edge, judge what the preceding
  // rising edge did against the snapshot taken one falling edge earlier.
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        checkOutput("rst_out_v", d, 32'(outV[d]), 32'd0);
        checkOutput("rst_in_rdy", d, 32'(inRdy[d]), 32'd0);
        checkOutput("rst_out_data", d, 32'(outData[d]), 32'd0);
        checkOutput("rst_sf_last", d, 32'(outSfl[d]), 32'd0);
        checkOutput("rst_last", d, 32'(outLast[d]), 32'd0);
        pos[d]       = 0;
        prevValid[d] = 1'b0;
      end else begin
        if (prevValid[d]) begin
          if (pLoad[d]) begin
            if (pos[d] < sfOf[d]) begin
              checkOutput("fill_out_v", d, 32'(outV[d]), 32'(pInAcc[d]));
              if (pInAcc[d]) begin
                vec[d][pos[d]] = pInData;
                expectWord(d);
              end
            end else begin
              checkOutput("replay_out_v", d, 32'(outV[d]), 32'd1);
              expectWord(d);
            end
          end else begin
            checkOutput("hold_out_v", d, 32'(outV[d]), 32'd1);
            checkOutput("hold_data", d, 32'(outData[d]), 32'(pData[d]));
            checkOutput("hold_sf_last", d, 32'(outSfl[d]), 32'(pSfl[d]));
            checkOutput("hold_last", d, 32'(outLast[d]), 32'(pLast[d]));
          end
        end
        checkOutput("in_rdy", d, 32'(inRdy[d]),
                    32'((!outV[d] || outRdy) && (pos[d] < sfOf[d])));
        prevValid[d] = 1'b1;
        pLoad[d]     = !outV[d] || outRdy;
        pInAcc[d]    = inV && inRdy[d];
        pData[d]     = outData[d];
        pSfl[d]      = outSfl[d];
        pLast[d]     = outLast[d];
        if (outV[d] && outRdy) begin
          e.data = outData[d];
          e.sfl  = outSfl[d];
          e.last = outLast[d];
          e.cyc  = cyc;
          if (d == 0) log0.push_back(e);
          if (d == 1) log1.push_back(e);
        end
      end
    end
    pInData = inData;
  end

  // out_rdy driver: always ready, the 1,0,0,1 pattern, or random.
  initial begin
    int phase;
    logic [3:0] rdyPat;
    rdyPat = 4'b1001;
    phase  = 0;
    outRdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdyMode)
        1:       outRdy = rdyPat[phase];
        2:       outRdy = ($urandom_range(0, 3) != 0);
        default: outRdy = 1'b1;
      endcase
      phase = (phase + 1) % 4;
    end
  end

  // Present one word on the input and hold it until dut 0 takes it.
  task automatic applyStimulus(input logic [W-1:0] data);
    bit ok;
    int n;
    ok     = 1'b0;
    n      = 0;
    inV    = 1'b1;
    inData = data;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = inRdy[0];
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) checkOutput("accept_timeout", 0, 32'd0, 32'd1);
  endtask

  // Send a 4-word vector (word 0 in the low byte) with optional idle gaps.
  task automatic sendVector(input logic [31:0] v, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (gap > 0 && i > 0) begin
        inV = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      applyStimulus(v[8*i +: 8]);
    end
    inV = 1'b0;
  endtask

  task automatic waitLog(input int n);
    int k;
    k = 0;
    while (log0.size() < n && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    checkOutput("log_size", 0, 32'(log0.size()), 32'(n));
  endtask

  // Literal expectations: the vector repeated 'passes' times from log0[base].
  task automatic checkVector(input string name, input logic [31:0] v,
                             input int passes, input int base);
    int n;
    n = 4 * passes;
    for (int i = 0; i < n; i++) begin
      if (base + i < log0.size()) begin
        checkOutput({name, "_data"}, 0, 32'(log0[base+i].data), 32'(v[8*(i%4) +: 8]));
        checkOutput({name, "_sfl"}, 0, 32'(log0[base+i].sfl), 32'((i % 4) == 3));
        checkOutput({name, "_last"}, 0, 32'(log0[base+i].last), 32'(i == n - 1));
      end
    end
  endtask

  task automatic clearLogs();
    log0.delete();
    log1.delete();
  endtask

  initial begin
    int gaps;
    inV    = 1'b0;
    inData = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] basic vector, no backpressure");
    clearLogs();
    sendVector(32'h76543210, 0);
    waitLog(12);
    checkVector("basic", 32'h76543210, 3, 0);
    // The NF=1 instance passes the same four words straight through.
    checkOutput("nf1_size", 1, 32'(log1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log1.size()) begin
        checkOutput("nf1_data", 1, 32'(log1[i].data), 32'(8'h10 + 8'h22 * i));
        checkOutput("nf1_last", 1, 32'(log1[i].last), 32'(i == 3));
        checkOutput("nf1_sfl", 1, 32'(log1[i].sfl), 32'(i == 3));
      end
    end

    $display("[TB] backpressure 1,0,0,1");
    clearLogs();
    rdyMode = 1;
    sendVector(32'h76543210, 0);
    waitLog(12);
    checkVector("bp", 32'h76543210, 3, 0);
    rdyMode = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] back-to-back vectors");
    clearLogs();
    sendVector(32'h76543210, 0);
    sendVector(32'hDCCBBAA9, 0);
    waitLog(24);
    checkVector("b2b_first", 32'h76543210, 3, 0);
    checkVector("b2b_second", 32'hDCCBBAA9, 3, 12);
    gaps = 0;
    for (int i = 0; i + 1 < log0.size(); i++) begin
      if (log0[i+1].cyc != log0[i].cyc + 1) gaps++;
    end
    checkOutput("b2b_gaps", 0, 32'(gaps), 32'd0);

    $display("[TB] reset during replay");
    clearLogs();
    sendVector(32'h76543210, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_v", 0, 32'(outV[0]), 32'd0);
    checkOutput("async_rst_in_rdy", 0, 32'(inRdy[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clearLogs();
    sendVector(32'h04030201, 0);
    waitLog(12);
    checkVector("post_rst", 32'h04030201, 3, 0);

    $display("[TB] input starvation");
    clearLogs();
    sendVector(32'h87654321, 3);
    waitLog(12);
    checkVector("starve", 32'h87654321, 3, 0);
    if (log0.size() == 12) begin
      checkOutput("starve_replay_span", 0, 32'(log0[11].cyc - log0[3].cyc), 32'd8);
    end

    $display("[TB] randomized traffic");
    rdyMode = 2;
    for (int c = 0; c < 3000; c++) begin
      inV    = ($urandom_range(0, 3) != 0);
      inData = W'($urandom_range(0, 255));
      rst    = ($urandom_range(0, 599) == 0);
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    inV     = 1'b0;
    rdyMode = 0;
    repeat (40) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvau_inp_buffer.md
# mvau_inp_buffer

Input-activation buffer sitting directly upstream of the matrix-vector unit in the Matrix-Vector-Activation Unit. It accepts one input vector as a stream of SF = MatrixW/SIMD words, each SIMD activations wide. It forwards each word to the MVU as it arrives and stores it. It then replays the stored vector NF-1 more times, NF = MatrixH/PE, so every PE fold sees the full vector. Both sides use valid/ready handshakes.

## Interface
- SIMD, 2, activations per word; equals the MVU SIMD
- TSrcI, 4, bits per activation
- MatrixW, 8, vector length in activations; must be a multiple of SIMD
- MatrixH, 6, matrix rows; must be a multiple of PE
- PE, 2, MVU PE count; determines NF
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-high reset (asserted = 1)
- in_v  in  1  input word valid
- in_rdy  out  1  buffer can accept an input word
- in_data  in  SIMD*TSrcI  input word; activation k occupies bits [k*TSrcI +: TSrcI]
- out_v  out  1  output word valid
- out_rdy  in  1  MVU accepts the output word
- out_data  out  SIMD*TSrcI  activation word to the MVU
- out_sf_last  out  1  out_data is word SF-1 of the current pass
- out_last  out  1  out_data is word SF-1 of pass NF-1, i.e. the last output for this vector

## Operation
- Derived values: SF = MatrixW/SIMD and NF = MatrixH/PE. Both must be ≥1; elaboration fails otherwise.
- Storage: SF words × SIMD*TSrcI bits. Reads are asynchronous (LUTRAM).
- Output register: out_v, out_data, out_sf_last, out_last. It loads when `load = !out_v | out_rdy`.
- Internal counters: wr_ptr / rd_ptr count 0..SF-1, and nf_cnt counts 0..NF-1.
- State FILL:
  - in_rdy = load.
  - On in_v & in_rdy, write in_data to mem[wr_ptr] and load it into the output register with out_v=1.
  - The output flags are out_sf_last=(wr_ptr==SF-1) and out_last=(wr_ptr==SF-1 & NF==1).
  - wr_ptr increments. At SF-1 it wraps to 0.
  - On that wrap, if NF>1 go to REPLAY with rd_ptr=0 and nf_cnt=1; otherwise stay in FILL.
  - If in_v=0 while load=1, out_v goes to 0.
- State REPLAY:
  - in_rdy=0.
  - When load=1, load mem[rd_ptr] with out_v=1. The output flags are out_sf_last=(rd_ptr==SF-1) and out_last=(rd_ptr==SF-1 & nf_cnt==NF-1).
  - rd_ptr increments. At SF-1 it wraps to 0 and nf_cnt increments.
  - On the load with rd_ptr==SF-1 and nf_cnt==NF-1, go to FILL, clear nf_cnt and wr_ptr.
- Output stability: while out_v=1 and out_rdy=0, out_data and both flags hold.
- Input data: in_data is ignored when in_v=0 or in_rdy=0.
- Storage is not reset. Contents are only read after being written in the current vector.

## Timing
- Reset values (asynchronous, while rst_n=1):
  - state = FILL
  - out_v = 0, out_sf_last = 0, out_last = 0, out_data = 0
  - all pointers and counters = 0
  - in_rdy is forced to 0
- Reset deassert: in_rdy=1 from the first cycle after rst_n falls.
- FILL latency: an input accepted at edge t appears on out_data after edge t (1 cycle).
- FILL→REPLAY: no bubble. The first replay word is loaded at the edge after the last fill word was loaded. This holds for SF=1 because writes complete at the edge and reads are asynchronous.
- REPLAY→FILL: no bubble. in_rdy can be 1 in the cycle after the last replay load.
- Throughput: with in_v=1 and out_rdy=1, one vector takes exactly SF*NF cycles and out_v stays high continuously.
- Reset mid-operation: the partial vector is discarded. Outputs take their reset values immediately, and the next accepted word is word 0 of a new vector.

## Test plan
Default parameters give SF=4 and NF=3.
- **Basic, no backpressure:**
  - Stimulus: inputs 0x10, 0x32, 0x54, 0x76 on consecutive cycles with out_rdy=1.
  - Required: out_data is 0x10, 0x32, 0x54, 0x76 repeated 3 times over 12 consecutive valid cycles.
  - out_sf_last is high on outputs 4, 8 and 12; out_last is high only on output 12.
  - in_rdy is low for output cycles 5–12.
- **Backpressure:**
  - Stimulus: same input, with out_rdy toggling 1,0,0,1,…
  - Required: the same 12-word sequence with no loss or duplication.
  - out_data holds stable while out_rdy=0, and in_rdy=0 whenever out_v=1 & out_rdy=0.
- **Back-to-back vectors:**
  - Stimulus: a second vector 0xA9, 0xBA, 0xCB, 0xDC presented immediately after the first.
  - Required: its first word appears in the cycle directly after the first vector's out_last.
  - Total of 24 valid cycles with no gaps.
- **Reset mid-replay:**
  - Stimulus: assert rst_n during pass 2, word 2, then send 0x01, 0x02, 0x03, 0x04.
  - Required: out_v drops asynchronously and in_rdy is 0 during reset.
  - The new vector is replayed 3 times with no stale data.
- **Degenerate configurations:**
  - NF=1 (MatrixH=2): pure pass-through with 1-cycle latency; out_last coincides with out_sf_last and in_rdy never drops with out_rdy=1.
  - SF=1 (MatrixW=2): every output has out_sf_last=1.
- **Input starvation:**
  - Stimulus: in_v gaps of 3 cycles between words in FILL.
  - Required: out_v=0 during the gaps and the sequence is intact. Replay still runs with no gaps.
